// File: rtl/bcd_counter_display_if.sv
// Board-side bundle for the BCD counter: control/load inputs in, count, wrap and display scan out.
// Master drives the controls; slave is the counter/display block.
interface bcd_counter_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    up;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   ctrl;
    logic [7:0]              segment;

    modport master (
        output en, up, load, load_value,
        input  count, wrap, ctrl, segment
    );

    modport slave (
        input  en, up, load, load_value,
        output count, wrap, ctrl, segment
    );
endinterface

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with multiplexed 7-segment scan; count, wrap and display are registered (1-cycle latency).
// No backpressure: prescalers free-run and every input is sampled on each clk edge.
module bcd_counter_display #(
    parameter int NUM_DIGITS       = 4,
    parameter int COUNT_DIV        = 1000,
    parameter int SCAN_DIV         = 2,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b0,
    parameter bit BLANK_LEADING    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    bcd_counter_display_if.slave bus
);
    localparam int CW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         COUNT_LAST = CW'(COUNT_DIV - 1);
    localparam logic [SW-1:0]         SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] CTRL_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [7:0]            SEG_OFF    = {8{SEG_ACTIVE_LOW}};

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    digits_t               cnt_q;
    digits_t               cnt_step;
    digits_t               load_clamped;
    logic                  carry;
    logic                  wrap_q;
    logic [CW-1:0]         cpre_q;
    logic                  count_tick;
    logic [SW-1:0]         spre_q;
    logic                  scan_tick;
    logic [IW-1:0]         idx_q;
    logic [3:0]            digit;
    logic                  blank;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] ctrl_d;
    logic [NUM_DIGITS-1:0] ctrl_q;
    logic [7:0]            seg_d;
    logic [7:0]            seg_q;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'b1111_1100;
            4'd1:    s = 8'b0110_0000;
            4'd2:    s = 8'b1101_1010;
            4'd3:    s = 8'b1111_0010;
            4'd4:    s = 8'b0110_0110;
            4'd5:    s = 8'b1011_0110;
            4'd6:    s = 8'b1011_1110;
            4'd7:    s = 8'b1110_0000;
            4'd8:    s = 8'b1111_1110;
            4'd9:    s = 8'b1111_0110;
            default: s = 8'b0000_0000;
        endcase
        return s;
    endfunction

    assign count_tick = (cpre_q == COUNT_LAST);
    assign scan_tick  = (spre_q == SCAN_LAST);

    // Out-of-range load nibbles saturate at 9 so the counter never holds a non-BCD digit.
    always_comb begin
        load_clamped = bus.load_value;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (load_clamped[k] > 4'd9) begin
                load_clamped[k] = 4'd9;
            end
        end
    end

    // Ripple increment/decrement; a carry surviving the top digit means the counter wrapped.
    always_comb begin
        cnt_step = cnt_q;
        carry    = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (bus.up) begin
                    if (cnt_q[k] == 4'd9) begin
                        cnt_step[k] = 4'd0;
                    end else begin
                        cnt_step[k] = cnt_q[k] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (cnt_q[k] == 4'd0) begin
                        cnt_step[k] = 4'd9;
                    end else begin
                        cnt_step[k] = cnt_q[k] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            cpre_q <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.load) begin
                cnt_q  <= load_clamped;
                cpre_q <= '0;
            end else begin
                cpre_q <= count_tick ? '0 : cpre_q + CW'(1);
                if (count_tick && bus.en) begin
                    cnt_q  <= cnt_step;
                    wrap_q <= carry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spre_q <= '0;
            idx_q  <= '0;
        end else begin
            spre_q <= scan_tick ? '0 : spre_q + SW'(1);
            if (scan_tick) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
        end
    end

    // A digit is blank when it and every digit above it are zero; the units digit always shows.
    always_comb begin
        digit = cnt_q[idx_q];
        blank = BLANK_LEADING && (idx_q != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(idx_q)) && (cnt_q[k] != 4'd0)) begin
                blank = 1'b0;
            end
        end
    end

    // Units digit sits on the MSB of ctrl.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            onehot[NUM_DIGITS-1-k] = (idx_q == IW'(k));
        end
        ctrl_d = onehot ^ CTRL_OFF;
        seg_d  = (blank ? 8'h00 : seg_code(digit)) ^ SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_OFF;
            seg_q  <= SEG_OFF;
        end else begin
            ctrl_q <= ctrl_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.count   = cnt_q;
    assign bus.wrap    = wrap_q;
    assign bus.ctrl    = ctrl_q;
    assign bus.segment = seg_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: directed scenarios plus randomized run against a decimal reference model.
module tb_bcd_counter_display;
    localparam int CDIV = 4;
    localparam int SDIV = 1;
    localparam int MAXV = 9999;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    bcd_counter_display_if #(.NUM_DIGITS(4)) if_a ();
    bcd_counter_display_if #(.NUM_DIGITS(4)) if_b ();
    bcd_counter_display_if #(.NUM_DIGITS(6)) if_c ();

    bcd_counter_display #(
        .NUM_DIGITS(4), .COUNT_DIV(CDIV), .SCAN_DIV(SDIV),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

    bcd_counter_display #(
        .NUM_DIGITS(4), .COUNT_DIV(CDIV), .SCAN_DIV(SDIV),
        .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    bcd_counter_display #(
        .NUM_DIGITS(6), .COUNT_DIV(3), .SCAN_DIV(2),
        .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_b.en         = if_a.en;
    assign if_b.up         = if_a.up;
    assign if_b.load       = if_a.load;
    assign if_b.load_value = if_a.load_value;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    int         pow10   [4]  = '{1, 10, 100, 1000};
    logic [3:0] scan_ctrl  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [7:0] scan_seg_a [4] = '{8'hDA, 8'h66, 8'h00, 8'h00};
    logic [7:0] scan_seg_b [4] = '{8'hDA, 8'h66, 8'hFC, 8'hFC};

    // Reference model: count held as a plain decimal integer.
    int         m_val;
    bit         m_wrap;
    int         m_cpre;
    int         m_spre;
    int         m_idx;
    logic [3:0] m_ctrl;
    logic [7:0] m_seg_a;
    logic [7:0] m_seg_b;
    int         m_d;
    bit         m_blank;

    function automatic int clamp_val(input logic [15:0] lv);
        int v = 0;
        int nib;
        for (int k = 3; k >= 0; k--) begin
            nib = int'(lv[k*4 +: 4]);
            if (nib > 9) nib = 9;
            v = v * 10 + nib;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t = v;
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_val   <= 0;
            m_wrap  <= 1'b0;
            m_cpre  <= 0;
            m_spre  <= 0;
            m_idx   <= 0;
            m_ctrl  <= 4'hF;
            m_seg_a <= 8'h00;
            m_seg_b <= 8'h00;
        end else begin
            m_d     = (m_val / pow10[m_idx]) % 10;
            m_blank = (m_idx > 0) && (m_val < pow10[m_idx]);
            m_ctrl  <= 4'(~(4'b1000 >> m_idx));
            m_seg_a <= m_blank ? 8'h00 : seg_tab[m_d];
            m_seg_b <= seg_tab[m_d];
            m_wrap  <= 1'b0;
            if (if_a.load) begin
                m_val  <= clamp_val(if_a.load_value);
                m_cpre <= 0;
            end else begin
                m_cpre <= (m_cpre == CDIV - 1) ? 0 : m_cpre + 1;
                if (m_cpre == CDIV - 1 && if_a.en) begin
                    if (if_a.up) begin
                        m_val  <= (m_val + 1) % (MAXV + 1);
                        m_wrap <= (m_val == MAXV);
                    end else begin
                        m_val  <= (m_val == 0) ? MAXV : m_val - 1;
                        m_wrap <= (m_val == 0);
                    end
                end
            end
            m_spre <= (m_spre == SDIV - 1) ? 0 : m_spre + 1;
            if (m_spre == SDIV - 1) m_idx <= (m_idx + 1) % 4;
        end
    end

    // Called at a negedge; load is seen by the next posedge and released at the following negedge.
    task automatic do_load(input logic [15:0] v);
        if_a.load       = 1'b1;
        if_a.load_value = v;
        @(negedge clk);
        if_a.load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (if_a.count !== 16'h0000 || if_a.wrap !== 1'b0) begin
                errors++;
                $display("FAIL reset_count count=%h wrap=%b expected 0000/0", if_a.count, if_a.wrap);
            end
            checks++;
            if (if_a.ctrl !== 4'b1111 || if_a.segment !== 8'h00) begin
                errors++;
                $display("FAIL reset_display ctrl=%b seg=%b expected 1111/00000000", if_a.ctrl, if_a.segment);
            end
            checks++;
            if (if_c.ctrl !== 6'b000000 || if_c.segment !== 8'hFF) begin
                errors++;
                $display("FAIL reset_polarity ctrl=%b seg=%b expected 000000/11111111", if_c.ctrl, if_c.segment);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if_a.ctrl !== 4'b0111 || if_a.segment !== 8'hFC) begin
            errors++;
            $display("FAIL reset_first_scan ctrl=%b seg=%b expected 0111/11111100", if_a.ctrl, if_a.segment);
        end
    endtask

    task automatic test_up_wrap();
        if_a.en = 1'b1;
        if_a.up = 1'b1;
        do_load(16'h0999);
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.count !== 16'h0999) begin
            errors++;
            $display("FAIL up_pretick count=%h expected 0999", if_a.count);
        end
        @(negedge clk);
        checks++;
        if (if_a.count !== 16'h1000 || if_a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL up_ripple count=%h wrap=%b expected 1000/0", if_a.count, if_a.wrap);
        end
        do_load(16'h9999);
        repeat (4) @(negedge clk);
        checks++;
        if (if_a.count !== 16'h0000 || if_a.wrap !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap count=%h wrap=%b expected 0000/1", if_a.count, if_a.wrap);
        end
        @(negedge clk);
        checks++;
        if (if_a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_pulse wrap=%b expected 0", if_a.wrap);
        end
    endtask

    task automatic test_down_wrap();
        if_a.up = 1'b0;
        do_load(16'h1000);
        repeat (4) @(negedge clk);
        checks++;
        if (if_a.count !== 16'h0999 || if_a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_borrow count=%h wrap=%b expected 0999/0", if_a.count, if_a.wrap);
        end
        do_load(16'h0000);
        repeat (4) @(negedge clk);
        checks++;
        if (if_a.count !== 16'h9999 || if_a.wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap count=%h wrap=%b expected 9999/1", if_a.count, if_a.wrap);
        end
        @(negedge clk);
        checks++;
        if (if_a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap_pulse wrap=%b expected 0", if_a.wrap);
        end
        if_a.en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (if_a.count !== 16'h9999 || if_a.wrap !== 1'b0) begin
                errors++;
                $display("FAIL enable_hold count=%h wrap=%b expected 9999/0", if_a.count, if_a.wrap);
            end
        end
    endtask

    task automatic test_load_collision();
        if_a.en = 1'b1;
        if_a.up = 1'b1;
        do_load(16'h1234);
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.count !== 16'h1234) begin
            errors++;
            $display("FAIL collide_pretick count=%h expected 1234", if_a.count);
        end
        do_load(16'h0A3F);
        checks++;
        if (if_a.count !== 16'h0939 || if_a.wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp count=%h wrap=%b expected 0939/0", if_a.count, if_a.wrap);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.count !== 16'h0939) begin
            errors++;
            $display("FAIL prescaler_restart count=%h expected 0939", if_a.count);
        end
        @(negedge clk);
        checks++;
        if (if_a.count !== 16'h0940) begin
            errors++;
            $display("FAIL after_load_tick count=%h expected 0940", if_a.count);
        end
    endtask

    task automatic test_scan_blank();
        int i;
        if_a.en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_load(16'h0042);
        checks++;
        if (if_a.ctrl !== 4'b0111 || if_a.segment !== 8'hFC) begin
            errors++;
            $display("FAIL scan_first ctrl=%b seg=%b expected 0111/11111100", if_a.ctrl, if_a.segment);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            i = k % 4;
            checks++;
            if (if_a.ctrl !== scan_ctrl[i] || if_a.segment !== scan_seg_a[i]) begin
                errors++;
                $display("FAIL scan_blank step=%0d ctrl=%b seg=%b expected %b/%b",
                         k, if_a.ctrl, if_a.segment, scan_ctrl[i], scan_seg_a[i]);
            end
            checks++;
            if (if_b.ctrl !== scan_ctrl[i] || if_b.segment !== scan_seg_b[i]) begin
                errors++;
                $display("FAIL scan_noblank step=%0d ctrl=%b seg=%b expected %b/%b",
                         k, if_b.ctrl, if_b.segment, scan_ctrl[i], scan_seg_b[i]);
            end
        end
    endtask

    task automatic test_polarity();
        int         step;
        logic [5:0] exp_ctrl;
        logic [7:0] exp_seg;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            step     = (j - 1) / 2;
            exp_ctrl = 6'(6'b100000 >> step);
            exp_seg  = (step == 0) ? 8'h03 : 8'hFF;
            checks++;
            if (if_c.ctrl !== exp_ctrl || if_c.segment !== exp_seg || if_c.count !== 24'h0) begin
                errors++;
                $display("FAIL polarity cyc=%0d ctrl=%b seg=%b count=%h expected %b/%b/000000",
                         j, if_c.ctrl, if_c.segment, if_c.count, exp_ctrl, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            @(negedge clk);
            checks++;
            if (if_a.count !== to_bcd(m_val) || if_a.wrap !== m_wrap) begin
                errors++;
                $display("FAIL random_count count=%h wrap=%b expected %h/%b",
                         if_a.count, if_a.wrap, to_bcd(m_val), m_wrap);
            end
            checks++;
            if (if_a.ctrl !== m_ctrl || if_a.segment !== m_seg_a || if_b.segment !== m_seg_b) begin
                errors++;
                $display("FAIL random_display ctrl=%b seg=%b segb=%b expected %b/%b/%b",
                         if_a.ctrl, if_a.segment, if_b.segment, m_ctrl, m_seg_a, m_seg_b);
            end
            rst             = ($urandom_range(0, 99) == 0);
            if_a.load       = ($urandom_range(0, 15) == 0);
            if_a.load_value = 16'($urandom);
            if_a.en         = ($urandom_range(0, 3) != 0);
            if_a.up         = 1'($urandom_range(0, 1));
        end
        rst       = 1'b0;
        if_a.load = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        if_a.en         = 1'b1;
        if_a.up         = 1'b1;
        if_a.load       = 1'b0;
        if_a.load_value = 16'h0;
        if_c.en         = 1'b0;
        if_c.up         = 1'b1;
        if_c.load       = 1'b0;
        if_c.load_value = 24'h0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_collision();
        test_scan_blank();
        test_polarity();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
